// File: rtl/mux16_16bit_reg_if.sv
// Word-select bus for mux16_16bit_reg: packed input words, index and capture
// enable toward the mux, registered word and valid flag back from it.
interface mux16_16bit_reg_if #(
  parameter int WIDTH  = 16,
  parameter int NWORDS = 16,
  parameter int SELW   = $clog2(NWORDS)
);
  logic                    EN;
  logic [WIDTH*NWORDS-1:0] IN;
  logic [SELW-1:0]         SEL;
  logic [WIDTH-1:0]        OUT;
  logic                    OUT_VALID;

  modport master (
    output EN,
    output IN,
    output SEL,
    input  OUT,
    input  OUT_VALID
  );

  modport slave (
    input  EN,
    input  IN,
    input  SEL,
    output OUT,
    output OUT_VALID
  );
endinterface

// File: rtl/mux16_16bit_reg.sv
// Registered 16-to-1 word multiplexer: one-hot decode of SEL gates each word,
// an OR tree merges them, and the result is captured on EN with one-cycle latency.
module mux16_16bit_reg #(
  parameter int WIDTH  = 16,
  parameter int NWORDS = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  mux16_16bit_reg_if.slave   bus
);
  localparam int SELW = $clog2(NWORDS);

  logic [NWORDS-1:0] sel_onehot;
  logic [WIDTH-1:0]  masked_word [NWORDS];
  logic [WIDTH-1:0]  sel_word;
  logic [WIDTH-1:0]  out_reg;
  logic              valid_reg;

  // Unselected words are forced to zero so they cannot leak X or stray bits.
  generate
    for (genvar gi = 0; gi < NWORDS; gi++) begin : g_word
      assign sel_onehot[gi]  = (bus.SEL == SELW'(gi));
      assign masked_word[gi] = bus.IN[gi*WIDTH +: WIDTH] & {WIDTH{sel_onehot[gi]}};
    end
  endgenerate

  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NWORDS; k++) begin
      sel_word = sel_word | masked_word[k];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (bus.EN) begin
      out_reg   <= sel_word;
      valid_reg <= 1'b1;
    end
  end

  assign bus.OUT       = out_reg;
  assign bus.OUT_VALID = valid_reg;
endmodule

// File: tb/tb_mux16_16bit_reg.sv
// Self-checking bench for mux16_16bit_reg: directed scenarios plus random
// traffic, checked every cycle against a shift-based reference model.
module tb_mux16_16bit_reg;
  logic clk;
  logic rst_n;

  mux16_16bit_reg_if ifc ();

  mux16_16bit_reg dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (ifc)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: word SEL of IN is just IN shifted right by 16*SEL.
  logic [15:0] exp_out;
  logic        exp_valid;
  bit          model_live = 0;

  always @(posedge clk) begin
    logic [255:0] shifted;
    shifted = ifc.IN >> (16 * int'(ifc.SEL));
    if (!rst_n) begin
      exp_out   = 16'h0000;
      exp_valid = 1'b0;
    end else if (ifc.EN) begin
      exp_out   = shifted[15:0];
      exp_valid = 1'b1;
    end
    model_live = 1;
  end

  always @(negedge clk) begin
    if (model_live) begin
      n_cmp++;
      if (ifc.OUT !== exp_out || ifc.OUT_VALID !== exp_valid) begin
        n_fail++;
        $display("FAIL model_cycle t=%0t out=%h valid=%b required out=%h valid=%b",
                 $time, ifc.OUT, ifc.OUT_VALID, exp_out, exp_valid);
      end
    end
  end

  task automatic check_lit(input string name, input logic [15:0] act_out, input logic act_v,
                           input logic [15:0] req_out, input logic req_v);
    n_cmp++;
    if (act_out !== req_out || act_v !== req_v) begin
      n_fail++;
      $display("FAIL %s out=%h valid=%b required out=%h valid=%b",
               name, act_out, act_v, req_out, req_v);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [3:0] s, input logic [255:0] d);
    @(negedge clk);
    rst_n   = r;
    ifc.EN  = e;
    ifc.SEL = s;
    ifc.IN  = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand_bus();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  logic [255:0] onehot_bus;
  logic [255:0] alt_bus;

  initial begin
    rst_n   = 1'b0;
    ifc.EN  = 1'b1;
    ifc.SEL = 4'd0;
    ifc.IN  = '0;
    for (int k = 0; k < 16; k++) begin
      onehot_bus[16*k +: 16] = 16'h0001 << k;
      alt_bus[16*k +: 16]    = (k % 2 == 0) ? 16'hA5A5 : 16'h5A5A;
    end

    // Reset dominates EN with live data on the bus.
    drive(1'b0, 1'b1, 4'd3, onehot_bus);
    drive(1'b0, 1'b1, 4'd9, onehot_bus);
    check_lit("reset_state", ifc.OUT, ifc.OUT_VALID, 16'h0000, 1'b0);

    for (int s = 0; s < 16; s++) begin
      drive(1'b1, 1'b1, 4'(s), onehot_bus);
      check_lit($sformatf("sweep_sel%0d", s), ifc.OUT, ifc.OUT_VALID, 16'h0001 << s, 1'b1);
    end

    drive(1'b1, 1'b1, 4'd5, onehot_bus);
    check_lit("hold_capture", ifc.OUT, ifc.OUT_VALID, 16'h0020, 1'b1);
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b0, 4'($urandom_range(0, 15)), rand_bus());
      check_lit($sformatf("hold_cycle%0d", c), ifc.OUT, ifc.OUT_VALID, 16'h0020, 1'b1);
    end

    drive(1'b1, 1'b1, 4'd14, alt_bus);
    check_lit("alt_sel14", ifc.OUT, ifc.OUT_VALID, 16'hA5A5, 1'b1);
    drive(1'b1, 1'b1, 4'd15, alt_bus);
    check_lit("alt_sel15", ifc.OUT, ifc.OUT_VALID, 16'h5A5A, 1'b1);

    // Reset in the middle of an enabled sweep, then recovery.
    drive(1'b1, 1'b1, 4'd2, onehot_bus);
    check_lit("midsweep_pre", ifc.OUT, ifc.OUT_VALID, 16'h0004, 1'b1);
    drive(1'b0, 1'b1, 4'd3, onehot_bus);
    check_lit("midsweep_reset", ifc.OUT, ifc.OUT_VALID, 16'h0000, 1'b0);
    drive(1'b1, 1'b0, 4'd4, onehot_bus);
    check_lit("post_reset_idle", ifc.OUT, ifc.OUT_VALID, 16'h0000, 1'b0);
    drive(1'b1, 1'b1, 4'd7, onehot_bus);
    check_lit("post_reset_load", ifc.OUT, ifc.OUT_VALID, 16'h0080, 1'b1);

    // Glitches between edges; only the values settled at the edge count.
    for (int g = 0; g < 4; g++) begin
      logic [3:0] fs;
      fs = 4'($urandom_range(0, 15));
      @(negedge clk);
      rst_n   = 1'b1;
      ifc.EN  = 1'b1;
      ifc.SEL = 4'($urandom_range(0, 15));
      ifc.IN  = rand_bus();
      #1 ifc.SEL = ~fs;
      ifc.IN = ~alt_bus;
      #1 check_lit($sformatf("glitch_hold%0d", g), ifc.OUT, ifc.OUT_VALID, exp_out, exp_valid);
      #1 ifc.SEL = fs;
      ifc.IN = onehot_bus;
      @(posedge clk);
      #1;
      check_lit($sformatf("glitch_edge%0d", g), ifc.OUT, ifc.OUT_VALID, 16'h0001 << fs, 1'b1);
    end

    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 19) != 0), ($urandom_range(0, 2) != 0),
            4'($urandom_range(0, 15)), rand_bus());
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
